rv_decode_queue: RTL and testbench

//  Registered RV32 instruction-decode stage with valid/ready handshakes on both sides and a BUF_DEPTH-entry decoded-instruction queue.

---
 rtl/rv_decode_queue.sv | 257 +++++++++++++++++++++++++
 tb/tb_rv_decode_queue.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/rv_decode_queue.sv
// RV32 decode stage: splits raw instruction words into fields/immediate, classifies legality and traps, queues results.
// Latency: an instruction accepted in cycle N is presented at the head in cycle N+1 when the queue was empty.
// Backpressure: in_ready = (count < BUF_DEPTH); out_* hold while out_valid & !out_ready; flush empties the queue.
//
// Ports:
//   clk, rst_n (sync, active-low), flush
//   in_valid/in_ready/in_instr/in_pc      fetch-side handshake
//   out_valid/out_ready + out_* fields     execute-side handshake, driven from the queue head register
module rv_decode_queue #(
    parameter int XLEN      = 32,
    parameter int BUF_DEPTH = 2,
    parameter bit EN_M      = 1'b1,
    parameter bit EN_ZICSR  = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_type,
    output logic            out_illegal,
    output logic            out_exc,
    output logic [3:0]      out_cause
);

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + 1);

    localparam logic [2:0] T_R    = 3'd0;
    localparam logic [2:0] T_I    = 3'd1;
    localparam logic [2:0] T_S    = 3'd2;
    localparam logic [2:0] T_B    = 3'd3;
    localparam logic [2:0] T_U    = 3'd4;
    localparam logic [2:0] T_J    = 3'd5;
    localparam logic [2:0] T_NONE = 3'd7;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        logic [2:0]      typ;
        logic            illegal;
        logic            exc;
        logic [3:0]      cause;
    } entry_t;

    // ---------------- decode (combinational on in_instr) ----------------
    entry_t             dec;
    logic [2:0]         typ;
    logic               legal;
    logic               is_ecall;
    logic               is_ebreak;
    logic signed [31:0] imm32;
    logic [2:0]         f3;
    logic [6:0]         f7;

    assign f3 = in_instr[14:12];
    assign f7 = in_instr[31:25];

    always_comb begin
        typ       = T_NONE;
        legal     = 1'b0;
        is_ecall  = 1'b0;
        is_ebreak = 1'b0;
        unique case (in_instr[6:0])
            OPC_LOAD: begin
                typ   = T_I;
                legal = (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
            end
            OPC_MISC: begin
                typ   = T_I;
                legal = (f3 inside {3'b000, 3'b001});
            end
            OPC_OPIMM: begin
                typ = T_I;
                // shift-immediates reuse the upper bits as a funct7 qualifier
                if (f3 == 3'b001)      legal = (f7 == 7'b0000000);
                else if (f3 == 3'b101) legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                else                   legal = 1'b1;
            end
            OPC_AUIPC, OPC_LUI: begin
                typ   = T_U;
                legal = 1'b1;
            end
            OPC_STORE: begin
                typ   = T_S;
                legal = (f3 inside {3'b000, 3'b001, 3'b010});
            end
            OPC_OP: begin
                typ = T_R;
                if (f7 == 7'b0000000)      legal = 1'b1;
                else if (f7 == 7'b0100000) legal = (f3 == 3'b000) || (f3 == 3'b101);
                else if (f7 == 7'b0000001) legal = EN_M;
                else                       legal = 1'b0;
            end
            OPC_BRANCH: begin
                typ   = T_B;
                legal = !(f3 inside {3'b010, 3'b011});
            end
            OPC_JALR: begin
                typ   = T_I;
                legal = (f3 == 3'b000);
            end
            OPC_JAL: begin
                typ   = T_J;
                legal = 1'b1;
            end
            OPC_SYSTEM: begin
                typ = T_I;
                if (f3 == 3'b000) begin
                    // only the exact ecall/ebreak words are valid privileged encodings
                    is_ecall  = (in_instr == 32'h0000_0073);
                    is_ebreak = (in_instr == 32'h0010_0073);
                    legal     = is_ecall || is_ebreak;
                end else if (f3 == 3'b100) begin
                    legal = 1'b0;
                end else begin
                    legal = EN_ZICSR;
                end
            end
            default: begin
                // covers every word with instr[1:0] != 2'b11 as well
                typ   = T_NONE;
                legal = 1'b0;
            end
        endcase
    end

    always_comb begin
        unique case (typ)
            T_I:     imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            T_S:     imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            T_B:     imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                              in_instr[30:25], in_instr[11:8], 1'b0};
            T_U:     imm32 = {in_instr[31:12], 12'b0};
            T_J:     imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                              in_instr[20], in_instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    always_comb begin
        dec         = '0;
        dec.pc      = in_pc;
        dec.opcode  = in_instr[6:0];
        if (!legal) begin
            // illegal words still expose the raw fields to help trap handling/debug
            dec.rd      = in_instr[11:7];
            dec.rs1     = in_instr[19:15];
            dec.rs2     = in_instr[24:20];
            dec.funct3  = f3;
            dec.funct7  = f7;
            dec.imm     = '0;
            dec.typ     = T_NONE;
            dec.illegal = 1'b1;
            dec.exc     = 1'b1;
            dec.cause   = 4'd2;
        end else begin
            dec.rd      = (typ inside {T_R, T_I, T_U, T_J}) ? in_instr[11:7]  : 5'd0;
            dec.rs1     = (typ inside {T_R, T_I, T_S, T_B}) ? in_instr[19:15] : 5'd0;
            dec.rs2     = (typ inside {T_R, T_S, T_B})      ? in_instr[24:20] : 5'd0;
            dec.funct3  = (typ inside {T_R, T_I, T_S, T_B}) ? f3              : 3'd0;
            dec.funct7  = (typ == T_R)                      ? f7              : 7'd0;
            dec.imm     = XLEN'(imm32);
            dec.typ     = typ;
            dec.illegal = 1'b0;
            dec.exc     = is_ecall || is_ebreak;
            dec.cause   = is_ecall ? 4'd11 : (is_ebreak ? 4'd3 : 4'd0);
        end
    end

    // ---------------- decoded-instruction queue ----------------
    entry_t        mem [BUF_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    assign in_ready  = (count < CW'(BUF_DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            // entries are cleared so the head-driven outputs read 0 out of reset
            for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= dec;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // outputs come straight from the head register, never from in_instr
    entry_t head;
    assign head = mem[rd_ptr];

    assign out_pc      = head.pc;
    assign out_opcode  = head.opcode;
    assign out_rd      = head.rd;
    assign out_rs1     = head.rs1;
    assign out_rs2     = head.rs2;
    assign out_funct3  = head.funct3;
    assign out_funct7  = head.funct7;
    assign out_imm     = head.imm;
    assign out_type    = head.typ;
    assign out_illegal = head.illegal;
    assign out_exc     = head.exc;
    assign out_cause   = head.cause;

endmodule

// File: tb/tb_rv_decode_queue.sv
// Directed bench for rv_decode_queue: decode vector table plus flow-control, flush and reset sequences.
// A second instance with EN_M=0/EN_ZICSR=0 shares the inputs to check the configurable legality.
module tb_rv_decode_queue;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;

    logic        in_ready, out_valid, out_illegal, out_exc;
    logic [31:0] out_pc, out_imm;
    logic [6:0]  out_opcode, out_funct7;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_funct3, out_type;
    logic [3:0]  out_cause;

    logic        n_in_ready, n_out_valid, n_out_illegal, n_out_exc;
    logic [31:0] n_out_pc, n_out_imm;
    logic [6:0]  n_out_opcode, n_out_funct7;
    logic [4:0]  n_out_rd, n_out_rs1, n_out_rs2;
    logic [2:0]  n_out_funct3, n_out_type;
    logic [3:0]  n_out_cause;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rv_decode_queue #(.XLEN(32), .BUF_DEPTH(2), .EN_M(1'b1), .EN_ZICSR(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
        .out_type(out_type), .out_illegal(out_illegal), .out_exc(out_exc), .out_cause(out_cause)
    );

    rv_decode_queue #(.XLEN(32), .BUF_DEPTH(2), .EN_M(1'b0), .EN_ZICSR(1'b0)) dut_nom (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(n_in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(n_out_valid), .out_ready(out_ready), .out_pc(n_out_pc),
        .out_opcode(n_out_opcode), .out_rd(n_out_rd), .out_rs1(n_out_rs1), .out_rs2(n_out_rs2),
        .out_funct3(n_out_funct3), .out_funct7(n_out_funct7), .out_imm(n_out_imm),
        .out_type(n_out_type), .out_illegal(n_out_illegal), .out_exc(n_out_exc), .out_cause(n_out_cause)
    );

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  typ;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        ill;
        logic        exc;
        logic [3:0]  cause;
        logic        nom_ill;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;

        // instr, type, rd, rs1, rs2, f3, f7, imm, illegal, exc, cause, illegal with EN_M=0/EN_ZICSR=0
        vecs = '{
            '{32'hFFF00093, 3'd1, 5'd1,  5'd0, 5'd0,  3'd0, 7'h00, 32'hFFFFFFFF, 1'b0, 1'b0, 4'd0,  1'b0}, // addi x1,x0,-1
            '{32'hFE208EE3, 3'd3, 5'd0,  5'd1, 5'd2,  3'd0, 7'h00, 32'hFFFFFFFC, 1'b0, 1'b0, 4'd0,  1'b0}, // beq x1,x2,-4
            '{32'h123452B7, 3'd4, 5'd5,  5'd0, 5'd0,  3'd0, 7'h00, 32'h12345000, 1'b0, 1'b0, 4'd0,  1'b0}, // lui x5
            '{32'h02208033, 3'd0, 5'd0,  5'd1, 5'd2,  3'd0, 7'h01, 32'h00000000, 1'b0, 1'b0, 4'd0,  1'b1}, // mul
            '{32'h00000073, 3'd1, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00, 32'h00000000, 1'b0, 1'b1, 4'd11, 1'b0}, // ecall
            '{32'h00000000, 3'd7, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00, 32'h00000000, 1'b1, 1'b1, 4'd2,  1'b1}, // all zero
            '{32'h00100073, 3'd1, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00, 32'h00000001, 1'b0, 1'b1, 4'd3,  1'b0}, // ebreak
            '{32'h300110F3, 3'd1, 5'd1,  5'd2, 5'd0,  3'd1, 7'h00, 32'h00000300, 1'b0, 1'b0, 4'd0,  1'b1}, // csrrw
            '{32'h0020A423, 3'd2, 5'd0,  5'd1, 5'd2,  3'd2, 7'h00, 32'h00000008, 1'b0, 1'b0, 4'd0,  1'b0}, // sw x2,8(x1)
            '{32'hFF9FF0EF, 3'd5, 5'd1,  5'd0, 5'd0,  3'd0, 7'h00, 32'hFFFFFFF8, 1'b0, 1'b0, 4'd0,  1'b0}, // jal x1,-8
            '{32'h40309093, 3'd7, 5'd1,  5'd1, 5'd3,  3'd1, 7'h20, 32'h00000000, 1'b1, 1'b1, 4'd2,  1'b1}, // slli bad funct7
            '{32'hFFF00090, 3'd7, 5'd1,  5'd0, 5'd31, 3'd0, 7'h7F, 32'h00000000, 1'b1, 1'b1, 4'd2,  1'b1}, // instr[1:0]=00
            '{32'hFFC12183, 3'd1, 5'd3,  5'd2, 5'd0,  3'd2, 7'h00, 32'hFFFFFFFC, 1'b0, 1'b0, 4'd0,  1'b0}, // lw x3,-4(x2)
            '{32'hFE20AEE3, 3'd7, 5'd29, 5'd1, 5'd2,  3'd2, 7'h7F, 32'h00000000, 1'b1, 1'b1, 4'd2,  1'b1}  // branch funct3=010
        };

        // ---- reset ----
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_pc",    64'(out_pc),    64'd0);
        chk("rst_out_imm",   64'(out_imm),   64'd0);
        chk("rst_out_type",  64'(out_type),  64'd0);

        // ---- decode table: push one, check the head next cycle, pop ----
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            in_valid = 1'b1;
            in_instr = vecs[i].instr;
            in_pc    = 32'h100 + 32'(4 * i);
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("v%0d_valid", i),   64'(out_valid),   64'd1);
            chk($sformatf("v%0d_pc", i),      64'(out_pc),      64'(32'h100 + 32'(4 * i)));
            chk($sformatf("v%0d_opcode", i),  64'(out_opcode),  64'(vecs[i].instr[6:0]));
            chk($sformatf("v%0d_type", i),    64'(out_type),    64'(vecs[i].typ));
            chk($sformatf("v%0d_rd", i),      64'(out_rd),      64'(vecs[i].rd));
            chk($sformatf("v%0d_rs1", i),     64'(out_rs1),     64'(vecs[i].rs1));
            chk($sformatf("v%0d_rs2", i),     64'(out_rs2),     64'(vecs[i].rs2));
            chk($sformatf("v%0d_funct3", i),  64'(out_funct3),  64'(vecs[i].f3));
            chk($sformatf("v%0d_funct7", i),  64'(out_funct7),  64'(vecs[i].f7));
            chk($sformatf("v%0d_imm", i),     64'(out_imm),     64'(vecs[i].imm));
            chk($sformatf("v%0d_illegal", i), 64'(out_illegal), 64'(vecs[i].ill));
            chk($sformatf("v%0d_exc", i),     64'(out_exc),     64'(vecs[i].exc));
            chk($sformatf("v%0d_cause", i),   64'(out_cause),   64'(vecs[i].cause));
            chk($sformatf("v%0d_nom_illegal", i), 64'(n_out_illegal), 64'(vecs[i].nom_ill));
            chk($sformatf("v%0d_nom_type", i),    64'(n_out_type),
                vecs[i].nom_ill ? 64'd7 : 64'(vecs[i].typ));
        end
        @(posedge clk);
        @(negedge clk);
        chk("table_drained", 64'(out_valid), 64'd0);

        // ---- backpressure: depth 2, third push refused, head stable ----
        out_ready = 1'b0;
        in_instr  = 32'hFFF00093;
        in_valid  = 1'b1; in_pc = 32'h200;
        chk("bp_ready0", 64'(in_ready), 64'd1);
        @(posedge clk); @(negedge clk);
        chk("bp_head0", 64'(out_pc), 64'h200);
        chk("bp_ready1", 64'(in_ready), 64'd1);
        in_pc = 32'h204;
        @(posedge clk); @(negedge clk);
        chk("bp_ready_full", 64'(in_ready), 64'd0);
        in_pc = 32'h208;
        @(posedge clk); @(negedge clk);
        chk("bp_still_full", 64'(in_ready), 64'd0);
        chk("bp_head_stable", 64'(out_pc), 64'h200);
        chk("bp_valid_stall", 64'(out_valid), 64'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("bp_order_2nd", 64'(out_pc), 64'h204);
        chk("bp_valid_2nd", 64'(out_valid), 64'd1);
        @(posedge clk); @(negedge clk);
        chk("bp_third_dropped", 64'(out_valid), 64'd0);

        // ---- streaming push+pop at count=1, then flush with a push ----
        in_valid = 1'b1; in_pc = 32'h300;
        @(posedge clk); @(negedge clk);
        for (int i = 0; i <= 10; i++) begin
            chk($sformatf("stream%0d_pc", i),    64'(out_pc),    64'(32'h300 + 32'(4 * i)));
            chk($sformatf("stream%0d_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("stream%0d_ready", i), 64'(in_ready),  64'd1);
            in_pc = 32'h300 + 32'(4 * (i + 1));
            if (i == 10) flush = 1'b1;
            @(posedge clk); @(negedge clk);
        end
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ready", 64'(in_ready),  64'd1);
        @(posedge clk); @(negedge clk);
        chk("flush_push_dropped", 64'(out_valid), 64'd0);

        // ---- reset with two entries queued ----
        out_ready = 1'b0;
        in_valid  = 1'b1; in_instr = 32'hFE208EE3; in_pc = 32'h500;
        @(posedge clk); @(negedge clk);
        in_pc = 32'h504;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        chk("pre_rst_full", 64'(in_ready), 64'd0);
        chk("pre_rst_imm",  64'(out_imm),  64'hFFFFFFFC);
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("mid_rst_valid",  64'(out_valid),  64'd0);
        chk("mid_rst_ready",  64'(in_ready),   64'd1);
        chk("mid_rst_pc",     64'(out_pc),     64'd0);
        chk("mid_rst_imm",    64'(out_imm),    64'd0);
        chk("mid_rst_rs1",    64'(out_rs1),    64'd0);
        chk("mid_rst_rs2",    64'(out_rs2),    64'd0);
        chk("mid_rst_opcode", 64'(out_opcode), 64'd0);
        chk("mid_rst_type",   64'(out_type),   64'd0);
        chk("mid_rst_exc",    64'(out_exc),    64'd0);
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("post_rst_empty", 64'(out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
